// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, framebuffer depth and test-bar colours
// for the VGA scanout block.
package vga_pkg;

    localparam int H_VIS    = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = 800;
    localparam int V_VIS    = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = 525;
    localparam int HS_START = 656;
    localparam int HS_END   = 751;
    localparam int VS_START = 490;
    localparam int VS_END   = 491;
    localparam int FB_DEPTH = 307200;

    typedef enum logic [2:0] {
        BAR_WHITE   = 3'd0,
        BAR_YELLOW  = 3'd1,
        BAR_CYAN    = 3'd2,
        BAR_GREEN   = 3'd3,
        BAR_MAGENTA = 3'd4,
        BAR_RED     = 3'd5,
        BAR_BLUE    = 3'd6,
        BAR_BLACK   = 3'd7
    } bar_e;

    localparam logic [11:0] RGB_WHITE   = 12'hFFF;
    localparam logic [11:0] RGB_YELLOW  = 12'hFF0;
    localparam logic [11:0] RGB_CYAN    = 12'h0FF;
    localparam logic [11:0] RGB_GREEN   = 12'h0F0;
    localparam logic [11:0] RGB_MAGENTA = 12'hF0F;
    localparam logic [11:0] RGB_RED     = 12'hF00;
    localparam logic [11:0] RGB_BLUE    = 12'h00F;
    localparam logic [11:0] RGB_BLACK   = 12'h000;

    function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
        logic [11:0] c;
        case (bar_e'(idx))
            BAR_WHITE:   c = RGB_WHITE;
            BAR_YELLOW:  c = RGB_YELLOW;
            BAR_CYAN:    c = RGB_CYAN;
            BAR_GREEN:   c = RGB_GREEN;
            BAR_MAGENTA: c = RGB_MAGENTA;
            BAR_RED:     c = RGB_RED;
            BAR_BLUE:    c = RGB_BLUE;
            default:     c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider and raster counters; exports the current position, raw
// sync/visible flags and a look-ahead of the position the next tick enters.
module vga_timing_gen #(
    parameter  int CLK_DIV   = 4,
    parameter  int H_VIS     = vga_pkg::H_VIS,
    parameter  int H_FP      = vga_pkg::H_FP,
    parameter  int H_SYNC    = vga_pkg::H_SYNC,
    parameter  int H_BP      = vga_pkg::H_BP,
    parameter  int V_VIS     = vga_pkg::V_VIS,
    parameter  int V_FP      = vga_pkg::V_FP,
    parameter  int V_SYNC    = vga_pkg::V_SYNC,
    parameter  int V_BP      = vga_pkg::V_BP,
    localparam int H_TOTAL_L = H_VIS + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL_L = V_VIS + V_FP + V_SYNC + V_BP,
    localparam int HW        = $clog2(H_TOTAL_L),
    localparam int VW        = $clog2(V_TOTAL_L)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_tick,
    output logic [HW-1:0] o_h,
    output logic [VW-1:0] o_v,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_vis,
    output logic          o_vis_next,
    output logic          o_origin_next
);
    import vga_pkg::*;

    localparam int DW       = $clog2(CLK_DIV);
    localparam int HS_FIRST = H_VIS + H_FP;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_VIS + V_FP;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          tick_s;

    // Divider wrap produces the tick; counters advance only on tick
    always_comb begin
        tick_s = (div_q == DW'(CLK_DIV - 1));
        div_d  = tick_s ? '0 : div_q + DW'(1);
        h_d    = h_q;
        v_d    = v_q;
        if (tick_s) begin
            if (h_q == HW'(H_TOTAL_L - 1)) begin
                h_d = '0;
                if (v_q == VW'(V_TOTAL_L - 1)) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + VW'(1);
                end
            end else begin
                h_d = h_q + HW'(1);
            end
        end else begin
            h_d = h_q;
        end
    end

    // Divider and raster position registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign o_tick        = tick_s;
    assign o_h           = h_q;
    assign o_v           = v_q;
    assign o_hs          = (h_q >= HW'(HS_FIRST)) && (h_q <= HW'(HS_LAST));
    assign o_vs          = (v_q >= VW'(VS_FIRST)) && (v_q <= VW'(VS_LAST));
    assign o_vis         = (h_q < HW'(H_VIS)) && (v_q < VW'(V_VIS));
    assign o_vis_next    = (h_d < HW'(H_VIS)) && (v_d < VW'(V_VIS));
    assign o_origin_next = (h_d == '0) && (v_d == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: framebuffer address generation one pixel ahead plus the
// registered sync/RGB output stage. Optional colour bars: VGA_SCANOUT_TESTPAT_EN.
module vga_scanout #(
    parameter  int ADDR_WIDTH = 19,
    parameter  int DATA_WIDTH = 12,
    parameter  int CLK_DIV    = 4,
    parameter  int H_VIS      = vga_pkg::H_VIS,
    parameter  int H_FP       = vga_pkg::H_FP,
    parameter  int H_SYNC     = vga_pkg::H_SYNC,
    parameter  int H_BP       = vga_pkg::H_BP,
    parameter  int V_VIS      = vga_pkg::V_VIS,
    parameter  int V_FP       = vga_pkg::V_FP,
    parameter  int V_SYNC     = vga_pkg::V_SYNC,
    parameter  int V_BP       = vga_pkg::V_BP,
    localparam int HW         = $clog2(H_VIS + H_FP + H_SYNC + H_BP),
    localparam int VW         = $clog2(V_VIS + V_FP + V_SYNC + V_BP)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic [ADDR_WIDTH-1:0] o_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
`ifdef VGA_SCANOUT_TESTPAT_EN
    input  logic                  i_testpat,
`endif
    output logic                  o_hsync,
    output logic                  o_vsync,
    output logic [3:0]            o_red,
    output logic [3:0]            o_green,
    output logic [3:0]            o_blue,
    output logic                  o_vblank,
    output logic                  o_frame_start
);
    import vga_pkg::*;

    logic          tick_s, hs_s, vs_s, vis_s, vis_next_s, origin_next_s;
    logic [HW-1:0] h_s;
    logic [VW-1:0] v_s;

    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, addr_q, addr_d;
    logic [DATA_WIDTH-1:0] rgb_q, rgb_d, pix_s;
    logic                  hsync_q, hsync_d, vsync_q, vsync_d;
    logic                  vblank_q, vblank_d, fs_q, fs_d;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) u_timing (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_tick        (tick_s),
        .o_h           (h_s),
        .o_v           (v_s),
        .o_hs          (hs_s),
        .o_vs          (vs_s),
        .o_vis         (vis_s),
        .o_vis_next    (vis_next_s),
        .o_origin_next (origin_next_s)
    );

    // Pixel source: framebuffer data, or colour bars keyed on the displayed column
    always_comb begin
`ifdef VGA_SCANOUT_TESTPAT_EN
        if (i_testpat) begin
            pix_s = bar_rgb(3'(h_s / HW'(H_VIS / 8)));
        end else begin
            pix_s = i_data;
        end
`else
        pix_s = i_data;
`endif
    end

    // Address pointer and output stage; the counters already hold the pixel
    // being registered to the pins, the look-ahead picks the next address
    always_comb begin
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        rgb_d    = rgb_q;
        vblank_d = vblank_q;
        fs_d     = 1'b0;
        if (tick_s) begin
            if (origin_next_s) begin
                addr_d = '0;
                ptr_d  = ADDR_WIDTH'(1);
            end else if (vis_next_s) begin
                addr_d = ptr_q;
                ptr_d  = ptr_q + ADDR_WIDTH'(1);
            end else begin
                addr_d = addr_q;
                ptr_d  = ptr_q;
            end
            hsync_d  = ~hs_s;
            vsync_d  = ~vs_s;
            rgb_d    = vis_s ? pix_s : '0;
            vblank_d = (v_s >= VW'(V_VIS));
            fs_d     = (h_s == '0) && (v_s == '0);
        end else begin
            fs_d = 1'b0;
        end
    end

    // Output and pointer registers; reset parks the raster at (0,0) with
    // address 0 already presented, so the pointer resumes at 1
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q    <= ADDR_WIDTH'(1);
            addr_q   <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            rgb_q    <= '0;
            vblank_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            rgb_q    <= rgb_d;
            vblank_q <= vblank_d;
            fs_q     <= fs_d;
        end
    end

    assign o_addr        = addr_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_red         = rgb_q[11:8];
    assign o_green       = rgb_q[7:4];
    assign o_blue        = rgb_q[3:0];
    assign o_vblank      = vblank_q;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: two instances (CLK_DIV 4 and 2) on a
// shrunken raster, each fed by a registered SRAM model with random contents.
module tb_vga_scanout;

    localparam int HV = 16, HF = 2, HSY = 3, HB = 3, HT = HV + HF + HSY + HB;
    localparam int VV = 6,  VF = 1, VSY = 2, VB = 2, VT = VV + VF + VSY + VB;
    localparam int FB = HV * VV;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        vb;
        logic        fs;
        logic [11:0] rgb;
        logic [18:0] addr;
    } px_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic testpat = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] mem [0:FB-1];

    logic [18:0] addr4, addr2;
    logic [11:0] data4, data2;
    logic        hs4, vs4, vb4, fs4, hs2, vs2, vb2, fs2;
    logic [3:0]  r4, g4, b4, r2, g2, b2;
    px_t         obs4, obs2;

    assign obs4 = {hs4, vs4, vb4, fs4, r4, g4, b4, addr4};
    assign obs2 = {hs2, vs2, vb2, fs2, r2, g2, b2, addr2};

    // Registered-read SRAM models
    always @(posedge clk) begin
        data4 <= (int'(addr4) < FB) ? mem[addr4] : 12'hABC;
        data2 <= (int'(addr2) < FB) ? mem[addr2] : 12'hABC;
    end

    vga_scanout #(.ADDR_WIDTH(19), .DATA_WIDTH(12), .CLK_DIV(4),
                  .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
                  .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)) dut4 (
        .i_clk(clk), .i_rst(rst), .o_addr(addr4), .i_data(data4),
`ifdef VGA_SCANOUT_TESTPAT_EN
        .i_testpat(testpat),
`endif
        .o_hsync(hs4), .o_vsync(vs4), .o_red(r4), .o_green(g4), .o_blue(b4),
        .o_vblank(vb4), .o_frame_start(fs4));

    vga_scanout #(.ADDR_WIDTH(19), .DATA_WIDTH(12), .CLK_DIV(2),
                  .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
                  .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)) dut2 (
        .i_clk(clk), .i_rst(rst), .o_addr(addr2), .i_data(data2),
`ifdef VGA_SCANOUT_TESTPAT_EN
        .i_testpat(testpat),
`endif
        .o_hsync(hs2), .o_vsync(vs2), .o_red(r2), .o_green(g2), .o_blue(b2),
        .o_vblank(vb2), .o_frame_start(fs2));

    px_t q4[$], q2[$];
    int  checks = 0, failures = 0;
    bit  active = 1'b0;

    task automatic cmp_px(input string name, input px_t got, input px_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got hs=%0b vs=%0b vb=%0b fs=%0b rgb=%h addr=%0d expected hs=%0b vs=%0b vb=%0b fs=%0b rgb=%h addr=%0d",
                     name, got.hs, got.vs, got.vb, got.fs, got.rgb, got.addr,
                     exp.hs, exp.vs, exp.vb, exp.fs, exp.rgb, exp.addr);
        end
    endtask

    task automatic cmp_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    function automatic logic [11:0] bar(input int i);
        logic [11:0] c;
        case (i)
            0: c = 12'hFFF;
            1: c = 12'hFF0;
            2: c = 12'h0FF;
            3: c = 12'h0F0;
            4: c = 12'hF0F;
            5: c = 12'hF00;
            6: c = 12'h00F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    // Reference: the idx-th pixel on the pins after a fresh frame start, and
    // the address presented while the raster sits one position further on
    function automatic px_t model(input int idx);
        px_t e;
        int h, v, c, ch, cv;
        h = idx % HT;
        v = (idx / HT) % VT;
        e.hs = !(h >= HV + HF && h < HV + HF + HSY);
        e.vs = !(v >= VV + VF && v < VV + VF + VSY);
        e.vb = (v >= VV);
        e.fs = (h == 0 && v == 0);
        if (h < HV && v < VV) e.rgb = testpat ? bar(h / (HV / 8)) : mem[v * HV + h];
        else                  e.rgb = 12'h000;
        c  = idx + 1;
        ch = c % HT;
        cv = (c / HT) % VT;
        if (cv < VV) e.addr = 19'(cv * HV + ((ch < HV) ? ch : HV - 1));
        else         e.addr = 19'(FB - 1);
        return e;
    endfunction

    int  k, last4, last2;
    px_t mon_e;

    // Monitor: a new pixel reaches the pins every CLK_DIV clocks after reset release
    always @(posedge clk) begin
        #1;
        if (active) begin
            k++;
            if (k % 4 == 0) begin
                if (q4.size() > 0) begin
                    mon_e = q4.pop_front();
                    cmp_px("px_div4", obs4, mon_e);
                end
                if (fs4) begin
                    if (last4 >= 0) cmp_int("frame_period_div4", k - last4, 4 * HT * VT);
                    last4 = k;
                end
            end else begin
                cmp_int("fs_width_div4", int'(fs4), 0);
            end
            if (k % 2 == 0) begin
                if (q2.size() > 0) begin
                    mon_e = q2.pop_front();
                    cmp_px("px_div2", obs2, mon_e);
                end
                if (fs2) begin
                    if (last2 >= 0) cmp_int("frame_period_div2", k - last2, 2 * HT * VT);
                    last2 = k;
                end
            end else begin
                cmp_int("fs_width_div2", int'(fs2), 0);
            end
        end else begin
            k     = 0;
            last4 = -1;
            last2 = -1;
        end
    end

    px_t rst_exp;
    int  npix;

    initial begin
        rst_exp = '{hs: 1'b1, vs: 1'b1, vb: 1'b0, fs: 1'b0, rgb: 12'h000, addr: 19'd0};
        rst = 1'b1;
        for (int run = 0; run < 4; run++) begin
            for (int a = 0; a < FB; a++) mem[a] = 12'($urandom);
`ifdef VGA_SCANOUT_TESTPAT_EN
            testpat = (run == 2);
`endif
            repeat (3) @(negedge clk);
            cmp_px("reset_div4", obs4, rst_exp);
            cmp_px("reset_div2", obs2, rst_exp);
            if (run == 0)      npix = 2 * HT * VT + 40;
            else if (run == 3) npix = HT * VT + 50;
            else               npix = $urandom_range(HT * VV - 1, HT + 1);
            for (int i = 0; i < npix; i++) begin
                q4.push_back(model(i));
                q2.push_back(model(i));
            end
            rst    = 1'b0;
            active = 1'b1;
            for (int c = 0; c < npix * 4 + 100 && (q4.size() != 0 || q2.size() != 0); c++)
                @(negedge clk);
            checks++;
            if (q4.size() != 0 || q2.size() != 0) begin
                failures++;
                $display("FAIL drain_timeout left4=%0d left2=%0d expected 0", q4.size(), q2.size());
                q4.delete();
                q2.delete();
            end
            // Asynchronous reset mid-frame, away from any clock edge
            #2;
            rst    = 1'b1;
            active = 1'b0;
            #1;
            cmp_px("async_reset_div4", obs4, rst_exp);
            cmp_px("async_reset_div2", obs2, rst_exp);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
